// File: rtl/param_fifo.sv
`default_nettype none
//==============================================================================
// Module      : param_fifo
// Description : Single-clock synchronous FIFO with any depth >= 2 (not limited
//               to powers of two). It has registered read data and registered
//               status flags, and the flags agree with count on every cycle.
//               Optional feature: define FIFO_ERR_FLAGS_EN to enable the
//               sticky overflow/underflow flags. Without it both are tied to 0.
// Revision    : 1.0 - initial release
//==============================================================================
module param_fifo #(
    parameter int WORD_SIZE  = 45,
    parameter int FIFO_DEPTH = 20,
    parameter int AF_LEVEL   = 18,
    parameter int AE_LEVEL   = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               write_enable,
    input  logic                               read_enable,
    input  logic [WORD_SIZE-1:0]               data_in,
    output logic [WORD_SIZE-1:0]               data_out,
    output logic                               empty_signal,
    output logic                               full_signal,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               overflow,
    output logic                               underflow
);

    // Occupancy needs one more code than there are entries.
    // The pointers only ever address valid entries.
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Storage. It is deliberately left out of reset, so it maps onto plain RAM.
    logic [WORD_SIZE-1:0] mem [0:FIFO_DEPTH-1];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             rd_accept;
    logic             wr_accept;

    // A pointer advances by one. For a non-power-of-two depth it must wrap
    // explicitly at the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A read is accepted only when the FIFO holds data. A write is accepted
    // when there is room, or when the same-cycle read frees an entry.
    assign rd_accept = read_enable & ~empty_signal;
    assign wr_accept = write_enable & (~full_signal | rd_accept);

    // Next occupancy. It feeds both the count register and the status flags,
    // so the flags never lag count.
    always_comb begin
        count_next = count;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Write port of the storage array (no reset on the contents).
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and the read data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_accept) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                data_out <= mem[rd_ptr];
            end
            count <= count_next;
        end
    end

    // Status flags are registered from the next occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            empty_signal <= 1'b1;
            full_signal  <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            empty_signal <= (count_next == '0);
            full_signal  <= (count_next == CNT_FULL);
            almost_empty <= (int'(count_next) <= AE_LEVEL);
            almost_full  <= (int'(count_next) >= AF_LEVEL);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic write_dropped;
    logic read_ignored;

    // The error conditions are taken from the same decisions that gate the
    // pointers, so a flag cannot disagree with what the datapath did.
    assign write_dropped = write_enable & ~wr_accept;
    assign read_ignored  = read_enable & empty_signal;

    // The error flags are sticky. Only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_dropped) begin
                overflow <= 1'b1;
            end
            if (read_ignored) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

`ifndef SYNTHESIS
    // Structural invariants of the occupancy logic.
    a_count_bound : assert property (@(posedge clk) disable iff (!reset)
        count <= CNT_FULL);
    a_empty_flag  : assert property (@(posedge clk) disable iff (!reset)
        empty_signal == (count == '0));
    a_full_flag   : assert property (@(posedge clk) disable iff (!reset)
        full_signal == (count == CNT_FULL));
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
//==============================================================================
// Module      : tb_param_fifo
// Description : Self-checking bench for param_fifo. A queue-based reference
//               model is checked on every clock edge and on the reset edge.
//               Directed steps carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_param_fifo;

    localparam int WORD_SIZE  = 45;
    localparam int FIFO_DEPTH = 20;
    localparam int AF_LEVEL   = 18;
    localparam int AE_LEVEL   = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                 clk;
    logic                 reset;
    logic                 write_enable;
    logic                 read_enable;
    logic [WORD_SIZE-1:0] data_in;
    logic [WORD_SIZE-1:0] data_out;
    logic                 empty_signal;
    logic                 full_signal;
    logic                 almost_full;
    logic                 almost_empty;
    logic [CNT_W-1:0]     count;
    logic                 overflow;
    logic                 underflow;

    param_fifo #(
        .WORD_SIZE  (WORD_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty_signal (empty_signal),
        .full_signal  (full_signal),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus expected registered read data.
    logic [WORD_SIZE-1:0] q[$];
    logic [WORD_SIZE-1:0] m_dout = '0;
    bit                   m_ovf  = 1'b0;
    bit                   m_unf  = 1'b0;
    bit                   m_rd;
    bit                   m_wr;

    // Model update on every edge, then compare all outputs shortly after.
    always begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            m_rd = read_enable && (q.size() != 0);
            m_wr = write_enable && ((q.size() < FIFO_DEPTH) || m_rd);
            if (read_enable && q.size() == 0) m_unf = 1'b1;
            if (write_enable && !m_wr)        m_ovf = 1'b1;
            if (m_rd) m_dout = q.pop_front();
            if (m_wr) q.push_back(data_in);
        end
        #1;
        check("m_count",        64'(count),        64'(q.size()));
        check("m_empty",        64'(empty_signal), 64'(q.size() == 0));
        check("m_full",         64'(full_signal),  64'(q.size() == FIFO_DEPTH));
        check("m_almost_full",  64'(almost_full),  64'(q.size() >= AF_LEVEL));
        check("m_almost_empty", 64'(almost_empty), 64'(q.size() <= AE_LEVEL));
        check("m_data_out",     64'(data_out),     64'(m_dout));
        check("m_overflow",     64'(overflow),     64'(ERR_EN & m_ovf));
        check("m_underflow",    64'(underflow),    64'(ERR_EN & m_unf));
    end

    // One clock of stimulus: inputs change at the falling edge. The task
    // returns after the model comparison for that rising edge.
    task automatic drive(input bit we, input bit re, input logic [WORD_SIZE-1:0] d);
        @(negedge clk);
        write_enable = we;
        read_enable  = re;
        data_in      = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset        = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        data_in      = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_count",  64'(count),        64'd0);
        check("rst_empty",  64'(empty_signal), 64'd1);
        check("rst_aempty", 64'(almost_empty), 64'd1);
        check("rst_full",   64'(full_signal),  64'd0);
        check("rst_dout",   64'(data_out),     64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fill with 0..19 and watch almost_full turn on at 18.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            drive(1'b1, 1'b0, WORD_SIZE'(i));
            if (i == 16) check("af_at17", 64'(almost_full), 64'd0);
            if (i == 17) check("af_at18", 64'(almost_full), 64'd1);
        end
        check("fill_full",  64'(full_signal), 64'd1);
        check("fill_count", 64'(count),       64'd20);

        // Write while full: the word is dropped.
        drive(1'b1, 1'b0, WORD_SIZE'('hAA));
        check("drop_count", 64'(count),    64'd20);
        check("drop_ovf",   64'(overflow), 64'(ERR_EN));

        // Drain in order.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            drive(1'b0, 1'b1, '0);
            check("drain_data", 64'(data_out), 64'(i));
        end
        check("drain_empty", 64'(empty_signal), 64'd1);
        check("drain_count", 64'(count),        64'd0);

        // Simultaneous read and write on empty: the write lands, the read is
        // ignored, and there is no bypass.
        drive(1'b1, 1'b1, WORD_SIZE'('h55));
        check("rw_empty_count", 64'(count),     64'd1);
        check("rw_empty_dout",  64'(data_out),  64'd19);
        check("rw_empty_unf",   64'(underflow), 64'(ERR_EN));

        // Refill to full: 0x55, 1001..1019.
        for (int i = 1; i < FIFO_DEPTH; i++) drive(1'b1, 1'b0, WORD_SIZE'(1000 + i));
        check("refill_full", 64'(full_signal), 64'd1);

        // Read and write together on full for 25 cycles (both pointers wrap).
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 1'b1, WORD_SIZE'(2000 + i));
            if (i == 0)      check("rw_full_data", 64'(data_out), 64'h55);
            else if (i < 20) check("rw_full_data", 64'(data_out), 64'(1000 + i));
            else             check("rw_full_data", 64'(data_out), 64'(2000 + i - 20));
            check("rw_full_count", 64'(count), 64'd20);
        end

        // Drain down to 10 entries, then reset asynchronously between edges.
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, '0);
        check("pre_rst_count", 64'(count), 64'd10);
        @(negedge clk);
        write_enable = 1'b0;
        read_enable  = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_count", 64'(count),        64'd0);
        check("arst_empty", 64'(empty_signal), 64'd1);
        check("arst_dout",  64'(data_out),     64'd0);
        check("arst_full",  64'(full_signal),  64'd0);
        @(negedge clk);
        reset = 1'b1;

        // After reset the FIFO behaves as empty.
        drive(1'b0, 1'b1, '0);
        check("post_rd_empty", 64'(data_out), 64'd0);
        drive(1'b1, 1'b0, WORD_SIZE'(7));
        drive(1'b1, 1'b0, WORD_SIZE'(8));
        drive(1'b0, 1'b1, '0);
        check("post_rd_7", 64'(data_out), 64'd7);
        drive(1'b1, 1'b1, WORD_SIZE'(9));
        check("post_rw_8",    64'(data_out), 64'd8);
        check("post_count_1", 64'(count),    64'd1);
        drive(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 45, data word width in bits (>=1).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 20, storage entries (>=2, any integer, not restricted to a power of 2).
REQ-003 The block SHALL have parameter AF_LEVEL, default 18, almost-full threshold in entries.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in entries.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port write_enable, input, 1 bit, write request.
REQ-008 The block SHALL have port read_enable, input, 1 bit, read request.
REQ-009 The block SHALL have port data_in, input, WORD_SIZE bits, write data.
REQ-010 The block SHALL have port data_out, output, WORD_SIZE bits, registered read data.
REQ-011 The block SHALL have port empty_signal, output, 1 bit, high when count==0.
REQ-012 The block SHALL have port full_signal, output, 1 bit, high when count==FIFO_DEPTH.
REQ-013 The block SHALL have port almost_full, output, 1 bit, high when count>=AF_LEVEL.
REQ-014 The block SHALL have port almost_empty, output, 1 bit, high when count<=AE_LEVEL.
REQ-015 The block SHALL have port count, output, $clog2(FIFO_DEPTH+1) bits, current occupancy.
REQ-016 The block SHALL have ports overflow and underflow, output, 1 bit each, sticky error flags.

Function
REQ-017 A write SHALL be accepted when write_enable=1 and (full_signal=0 or a read is accepted the same cycle); data_in is stored at the write pointer.
REQ-018 A read SHALL be accepted when read_enable=1 and empty_signal=0; data_out is loaded with the head entry on that same edge (1-cycle latency).
REQ-019 data_out SHALL hold its value on every cycle with no accepted read.
REQ-020 Write on full without a simultaneous read SHALL be dropped, with pointers, count and memory unchanged.
REQ-021 Read on empty SHALL be ignored; no write-to-read bypass, even if a write is accepted the same cycle.
REQ-022 Simultaneous accepted read and write SHALL leave count unchanged and advance both pointers.
REQ-023 Each pointer SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-024 count SHALL change by +1 on write only, by -1 on read only, and never exceed FIFO_DEPTH or go below 0.
REQ-025 All status flags SHALL be registered and consistent with count in the same cycle (no extra cycle lag).

Reset
REQ-026 reset=0 SHALL asynchronously clear pointers and count to 0, set empty_signal=1, almost_empty=1, full_signal=0, almost_full=0, overflow=0, underflow=0, and data_out=0.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries; the first cycle after deassertion behaves as an empty FIFO.

Configuration
REQ-029 With macro FIFO_ERR_FLAGS_EN defined, overflow SHALL set on a dropped write and underflow SHALL set on an ignored read, and both SHALL stay set until reset.
REQ-030 Without FIFO_ERR_FLAGS_EN, overflow and underflow SHALL be tied to 0, with ports still present.

Verification
REQ-031 Reset, then write 20 words 0..19 -> full_signal=1 and count=20 after the 20th edge, almost_full=1 from count=18.
REQ-032 From full, read 20 times -> data_out=0..19 in order, each valid on the accepted-read edge, empty_signal=1 at the end.
REQ-033 From full, write 0xAA with read_enable=0 -> write dropped, count=20; with FIFO_ERR_FLAGS_EN, overflow=1.
REQ-034 From full, write and read together -> data_out=head, count stays 20, new word appears last; repeat 25 cycles to exercise pointer wrap.
REQ-035 From empty, write and read together -> count=1, data_out unchanged, underflow=1 only with FIFO_ERR_FLAGS_EN.
REQ-036 At count=10, drive reset=0 asynchronously between edges -> count=0, empty_signal=1 and data_out=0 immediately.
